// File: rtl/bcd_gate_7seg.sv
// Registered BCD-to-seven-segment decoder with lamp test, blanking and an invalid-code flag.
// Define BCD_GATE_HEX_DIGITS_EN to show codes 10-15 as hex glyphs instead of blanking them.
module bcd_gate_7seg (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic       bi,
  input  logic       lt,
  output logic [6:0] y,
  output logic       err
);

  logic [6:0] digit_y;
  logic       digit_err;
  logic [6:0] next_y;
  logic       next_err;

  // Segment order is {a,b,c,d,e,f,g}; codes above 9 depend on the build.
  always_comb begin
    digit_y   = 7'h00;
    digit_err = 1'b0;
    case (a)
      4'd0:  digit_y = 7'h7E;
      4'd1:  digit_y = 7'h30;
      4'd2:  digit_y = 7'h6D;
      4'd3:  digit_y = 7'h79;
      4'd4:  digit_y = 7'h33;
      4'd5:  digit_y = 7'h5B;
      4'd6:  digit_y = 7'h5F;
      4'd7:  digit_y = 7'h70;
      4'd8:  digit_y = 7'h7F;
      4'd9:  digit_y = 7'h7B;
`ifdef BCD_GATE_HEX_DIGITS_EN
      4'd10: digit_y = 7'h77;
      4'd11: digit_y = 7'h1F;
      4'd12: digit_y = 7'h4E;
      4'd13: digit_y = 7'h3D;
      4'd14: digit_y = 7'h4F;
      4'd15: digit_y = 7'h47;
`else
      default: begin
        digit_y   = 7'h00;
        digit_err = 1'b1;
      end
`endif
    endcase
  end

  // Blanking beats lamp test; both suppress the error flag.
  always_comb begin
    next_y   = digit_y;
    next_err = digit_err;
    if (bi) begin
      next_y   = 7'h00;
      next_err = 1'b0;
    end else if (lt) begin
      next_y   = 7'h7F;
      next_err = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y   <= 7'h00;
      err <= 1'b0;
    end else begin
      y   <= next_y;
      err <= next_err;
    end
  end

endmodule

// File: tb/tb_bcd_gate_7seg.sv
// Self-checking bench for bcd_gate_7seg: directed vector table, corner sequences, random vs. glyph model.
// Build with +define+BCD_GATE_HEX_DIGITS_EN to check the hex-glyph variant.
module tb_bcd_gate_7seg;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic       bi;
  logic       lt;
  logic [6:0] y;
  logic       err;

  int checks = 0;
  int errors = 0;

  bcd_gate_7seg dut (
    .clk(clk),
    .rst(rst),
    .a(a),
    .bi(bi),
    .lt(lt),
    .y(y),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyphs described by which segment letters are lit.
  string glyph [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  function automatic logic [6:0] seg_of(input string s);
    logic [6:0] r;
    r = 7'h00;
    for (int i = 0; i < s.len(); i++) r[6 - (int'(s[i]) - 97)] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] model(input logic [3:0] code, input logic blank, input logic lamp);
    if (blank) return 8'h00;
    if (lamp) return {1'b0, seg_of("abcdefg")};
    if (code <= 4'd9) return {1'b0, seg_of(glyph[code])};
`ifdef BCD_GATE_HEX_DIGITS_EN
    return {1'b0, seg_of(glyph[code])};
`else
    return {1'b1, 7'h00};
`endif
  endfunction

  typedef struct {
    logic [3:0] a;
    logic       bi;
    logic       lt;
    logic [6:0] y;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  task automatic apply_stimulus(input logic [3:0] code, input logic blank, input logic lamp);
    @(negedge clk);
    a  = code;
    bi = blank;
    lt = lamp;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [6:0] exp_y, input logic exp_err);
    checks++;
    if (y !== exp_y || err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s: got y=%h err=%b, expected y=%h err=%b", name, y, err, exp_y, exp_err);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] m;
    logic [3:0] ra;
    logic       rbi;
    logic       rlt;

    rst = 1'b1;
    a   = 4'd0;
    bi  = 1'b0;
    lt  = 1'b0;
    #3;
    check_output("reset_state", 7'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{4'd0,  1'b0, 1'b0, 7'h7E, 1'b0});
    vecs.push_back('{4'd1,  1'b0, 1'b0, 7'h30, 1'b0});
    vecs.push_back('{4'd2,  1'b0, 1'b0, 7'h6D, 1'b0});
    vecs.push_back('{4'd3,  1'b0, 1'b0, 7'h79, 1'b0});
    vecs.push_back('{4'd4,  1'b0, 1'b0, 7'h33, 1'b0});
    vecs.push_back('{4'd5,  1'b0, 1'b0, 7'h5B, 1'b0});
    vecs.push_back('{4'd6,  1'b0, 1'b0, 7'h5F, 1'b0});
    vecs.push_back('{4'd7,  1'b0, 1'b0, 7'h70, 1'b0});
    vecs.push_back('{4'd8,  1'b0, 1'b0, 7'h7F, 1'b0});
    vecs.push_back('{4'd9,  1'b0, 1'b0, 7'h7B, 1'b0});
`ifdef BCD_GATE_HEX_DIGITS_EN
    vecs.push_back('{4'd10, 1'b0, 1'b0, 7'h77, 1'b0});
    vecs.push_back('{4'd11, 1'b0, 1'b0, 7'h1F, 1'b0});
    vecs.push_back('{4'd12, 1'b0, 1'b0, 7'h4E, 1'b0});
    vecs.push_back('{4'd13, 1'b0, 1'b0, 7'h3D, 1'b0});
    vecs.push_back('{4'd14, 1'b0, 1'b0, 7'h4F, 1'b0});
    vecs.push_back('{4'd15, 1'b0, 1'b0, 7'h47, 1'b0});
`else
    for (int c = 10; c < 16; c++) vecs.push_back('{4'(c), 1'b0, 1'b0, 7'h00, 1'b1});
`endif
    vecs.push_back('{4'd1,  1'b0, 1'b1, 7'h7F, 1'b0});
    vecs.push_back('{4'd1,  1'b0, 1'b0, 7'h30, 1'b0});
    vecs.push_back('{4'd12, 1'b1, 1'b1, 7'h00, 1'b0});
    vecs.push_back('{4'd14, 1'b0, 1'b1, 7'h7F, 1'b0});
    vecs.push_back('{4'd8,  1'b1, 1'b0, 7'h00, 1'b0});
    vecs.push_back('{4'd11, 1'b1, 1'b0, 7'h00, 1'b0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].a, vecs[i].bi, vecs[i].lt);
      check_output($sformatf("vec%0d_a%0d", i, vecs[i].a), vecs[i].y, vecs[i].err);
    end

    // Back-to-back 0/1: new value after each edge, old value still held before it.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a  = (i % 2 == 0) ? 4'd0 : 4'd1;
      bi = 1'b0;
      lt = 1'b0;
      #1;
      if (i > 0) check_output($sformatf("b2b_hold%0d", i), (i % 2 == 0) ? 7'h30 : 7'h7E, 1'b0);
      @(posedge clk);
      #1;
      check_output($sformatf("b2b_new%0d", i), (i % 2 == 0) ? 7'h7E : 7'h30, 1'b0);
    end

    // Asynchronous reset mid-stream with 8 displayed.
    apply_stimulus(4'd8, 1'b0, 1'b0);
    check_output("pre_reset_8", 7'h7F, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_reset", 7'h00, 1'b0);
    @(posedge clk);
    #1;
    check_output("reset_held", 7'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset_release_no_edge", 7'h00, 1'b0);
    @(posedge clk);
    #1;
    check_output("first_after_reset", 7'h7F, 1'b0);

    // Randomized traffic against the glyph model.
    for (int i = 0; i < 300; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rbi = ($urandom_range(0, 4) == 0);
      rlt = ($urandom_range(0, 4) == 0);
      apply_stimulus(ra, rbi, rlt);
      m = model(ra, rbi, rlt);
      check_output($sformatf("rand%0d_a%0d_bi%0b_lt%0b", i, ra, rbi, rlt), m[6:0], m[7]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
